// File: rtl/vending_machine.sv
// Six-slot vending machine with supplier restock and user purchase modes.
// Optional cancel/refund on enter_key with no button is enabled by VM_CANCEL_REFUND_EN.
module vending_machine (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_s,
  input  logic [2:0] item_s,
  input  logic [3:0] count_s,
  input  logic [7:0] cost_s,
  input  logic       enter_key,
  input  logic [1:0] coins,
  input  logic [5:0] button,
  output logic       dispense,
  output logic [2:0] dispense_item,
  output logic [7:0] change,
  output logic       refund,
  output logic [7:0] balance,
  output logic       sold_out,
  output logic       insufficient,
  output logic       coin_reject
);

  localparam int NUM_SLOTS = 6;

  logic [3:0] count_q [NUM_SLOTS];
  logic [7:0] cost_q  [NUM_SLOTS];

  logic [7:0] coin_val;
  logic       one_hot;
  logic [2:0] sel;
  logic [3:0] sel_count;
  logic [7:0] sel_cost;
  logic       restock;
  logic [2:0] restock_idx;
  logic [7:0] bal_base;
  logic [8:0] sum;

  logic       vend_n, sold_n, insuf_n, refund_n, reject_n;
  logic [2:0] item_n;
  logic [7:0] change_n, bal_n;

  always_comb begin
    case (coins)
      2'd1:    coin_val = 8'd5;
      2'd2:    coin_val = 8'd10;
      2'd3:    coin_val = 8'd25;
      default: coin_val = 8'd0;
    endcase
  end

  // Exactly one button bit set; sel falls back to slot 0 when none is pressed.
  assign one_hot = (button != 6'd0) && ((button & (button - 6'd1)) == 6'd0);

  always_comb begin
    sel = 3'd0;
    for (int i = 0; i < NUM_SLOTS; i++)
      if (button[i]) sel = 3'(i);
  end

  assign sel_count   = count_q[sel];
  assign sel_cost    = cost_q[sel];
  assign restock     = valid_s && enter_key && (item_s != 3'd0) && (item_s != 3'd7);
  assign restock_idx = item_s - 3'd1;

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    vend_n   = 1'b0;
    sold_n   = 1'b0;
    insuf_n  = 1'b0;
    refund_n = 1'b0;
    reject_n = 1'b0;
    item_n   = 3'd0;
    change_n = 8'd0;
    bal_base = balance;
    sum      = 9'd0;
    bal_n    = balance;
    if (!valid_s) begin
      if (enter_key && one_hot) begin
        if (sel_count == 4'd0) begin
          sold_n = 1'b1;
        end else if (balance < sel_cost) begin
          insuf_n = 1'b1;
        end else begin
          vend_n   = 1'b1;
          item_n   = sel + 3'd1;
          change_n = balance - sel_cost;
          bal_base = 8'd0;
        end
      end
`ifdef VM_CANCEL_REFUND_EN
      else if (enter_key && (button == 6'd0)) begin
        refund_n = 1'b1;
        change_n = balance;
        bal_base = 8'd0;
      end
`endif
      // The coin lands on the balance left after this cycle's vend/cancel decision.
      sum   = {1'b0, bal_base} + {1'b0, coin_val};
      bal_n = bal_base;
      if (coins != 2'd0) begin
        if (sum[8]) reject_n = 1'b1;
        else        bal_n    = sum[7:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: slot registers are reset because a fresh machine must report every slot sold out.
      for (int i = 0; i < NUM_SLOTS; i++) begin
        count_q[i] <= 4'd0;
        cost_q[i]  <= 8'd0;
      end
      balance       <= 8'd0;
      change        <= 8'd0;
      dispense_item <= 3'd0;
      dispense      <= 1'b0;
      refund        <= 1'b0;
      sold_out      <= 1'b0;
      insufficient  <= 1'b0;
      coin_reject   <= 1'b0;
    end else begin
      if (restock) begin
        count_q[restock_idx] <= count_s;
        cost_q[restock_idx]  <= cost_s;
      end
      if (vend_n) count_q[sel] <= sel_count - 4'd1;
      balance       <= bal_n;
      change        <= change_n;
      dispense_item <= item_n;
      dispense      <= vend_n;
      refund        <= refund_n;
      sold_out      <= sold_n;
      insufficient  <= insuf_n;
      coin_reject   <= reject_n;
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// Directed self-checking bench for vending_machine; cancel checks follow VM_CANCEL_REFUND_EN.
module tb_vending_machine;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_s;
  logic [2:0] item_s;
  logic [3:0] count_s;
  logic [7:0] cost_s;
  logic       enter_key;
  logic [1:0] coins;
  logic [5:0] button;
  logic       dispense;
  logic [2:0] dispense_item;
  logic [7:0] change;
  logic       refund;
  logic [7:0] balance;
  logic       sold_out;
  logic       insufficient;
  logic       coin_reject;

  int checks = 0;
  int errors = 0;

  vending_machine dut (
    .clk(clk), .rst(rst), .valid_s(valid_s), .item_s(item_s), .count_s(count_s),
    .cost_s(cost_s), .enter_key(enter_key), .coins(coins), .button(button),
    .dispense(dispense), .dispense_item(dispense_item), .change(change), .refund(refund),
    .balance(balance), .sold_out(sold_out), .insufficient(insufficient),
    .coin_reject(coin_reject)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_s = 1'b0; item_s = 3'd0; count_s = 4'd0; cost_s = 8'd0;
    enter_key = 1'b0; coins = 2'd0; button = 6'd0;
  endtask

  task automatic do_restock(input logic [2:0] item, input logic [3:0] cnt, input logic [7:0] cost);
    valid_s = 1'b1; item_s = item; count_s = cnt; cost_s = cost; enter_key = 1'b1;
    tick();
    idle();
  endtask

  task automatic do_coin(input logic [1:0] c);
    coins = c;
    tick();
    coins = 2'd0;
  endtask

  task automatic do_select(input logic [5:0] b, input logic [1:0] c);
    enter_key = 1'b1; button = b; coins = c;
    tick();
    idle();
  endtask

  task automatic check_flags(input string tag, input logic d, input logic s,
                             input logic ins, input logic rej, input logic rf);
    check({tag, "_dispense"}, dispense, d);
    check({tag, "_sold_out"}, sold_out, s);
    check({tag, "_insufficient"}, insufficient, ins);
    check({tag, "_coin_reject"}, coin_reject, rej);
    check({tag, "_refund"}, refund, rf);
  endtask

  initial begin
    idle();
    // Reset wins over a coin and an enter_key presented at the same edges.
    rst = 1'b1; coins = 2'd3; enter_key = 1'b1; button = 6'b000100;
    tick(); tick();
    check("rst_balance", balance, 0);
    check("rst_change", change, 0);
    check("rst_item", dispense_item, 0);
    check_flags("rst", 0, 0, 0, 0, 0);
    rst = 1'b0;
    idle();
    tick();

    // Empty slot after reset.
    do_select(6'b000100, 2'd0);
    check("empty_sold_out", sold_out, 1);
    check("empty_balance", balance, 0);
    check("empty_dispense", dispense, 0);
    tick();
    check("empty_pulse_end", sold_out, 0);

    // Restock slot 2 (item_s 3): count 2, cost 30; 25+10 then vend.
    do_restock(3'd3, 4'd2, 8'd30);
    do_coin(2'd3);
    check("coin_q", balance, 25);
    do_coin(2'd2);
    check("coin_d", balance, 35);
    do_select(6'b000100, 2'd0);
    check_flags("vend1", 1, 0, 0, 0, 0);
    check("vend1_item", dispense_item, 3);
    check("vend1_change", change, 5);
    check("vend1_balance", balance, 0);
    tick();
    check("vend1_pulse_end", dispense, 0);
    check("vend1_item_end", dispense_item, 0);
    check("vend1_change_end", change, 0);

    // Last item out with exact credit, then the slot reports sold out.
    do_coin(2'd3);
    do_coin(2'd1);
    check("bal_30", balance, 30);
    do_select(6'b000100, 2'd0);
    check("vend2_dispense", dispense, 1);
    check("vend2_change", change, 0);
    do_coin(2'd3);
    do_coin(2'd3);
    do_select(6'b000100, 2'd0);
    check_flags("vend3", 0, 1, 0, 0, 0);
    check("vend3_balance", balance, 50);

    // Supplier mode ignores coins and buttons; balance survives the mode change.
    valid_s = 1'b1; item_s = 3'd2; count_s = 4'd5; cost_s = 8'd50; enter_key = 1'b1;
    coins = 2'd3; button = 6'b000010;
    tick();
    idle();
    check("sup_balance", balance, 50);
    check_flags("sup", 0, 0, 0, 0, 0);

    // Credit equal to price vends with zero change.
    do_select(6'b000010, 2'd0);
    check("vend4_dispense", dispense, 1);
    check("vend4_item", dispense_item, 2);
    check("vend4_change", change, 0);
    check("vend4_balance", balance, 0);

    // Quarter against a 50-cent slot.
    do_coin(2'd3);
    do_select(6'b000010, 2'd0);
    check_flags("insuf", 0, 0, 1, 0, 0);
    check("insuf_balance", balance, 25);

    // Two buttons together: nothing happens.
    do_select(6'b000110, 2'd0);
    check_flags("multi", 0, 0, 0, 0, 0);
    check("multi_balance", balance, 25);

    // Coin with selection: decision on 25 (insufficient), coin still added.
    do_select(6'b000010, 2'd3);
    check("cs1_insufficient", insufficient, 1);
    check("cs1_balance", balance, 50);
    // Decision on 50 vends, then the nickel lands on the cleared balance.
    do_select(6'b000010, 2'd1);
    check("cs2_dispense", dispense, 1);
    check("cs2_change", change, 0);
    check("cs2_balance", balance, 5);

    do_coin(2'd3);
    do_coin(2'd1);
    check("bal_35", balance, 35);
    do_select(6'b000000, 2'd0);
`ifdef VM_CANCEL_REFUND_EN
    check("cancel_refund", refund, 1);
    check("cancel_change", change, 35);
    check("cancel_balance", balance, 0);
    tick();
    check("cancel_pulse_end", refund, 0);
`else
    check("cancel_refund", refund, 0);
    check("cancel_change", change, 0);
    check("cancel_balance", balance, 35);
`endif

    // Reset clears slots; overflow handling at the 255 ceiling.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst2_balance", balance, 0);
    do_select(6'b000010, 2'd0);
    check("rst2_sold_out", sold_out, 1);
    for (int i = 0; i < 10; i++) do_coin(2'd3);
    check("bal_250", balance, 250);
    do_coin(2'd2);
    check("ovf_reject", coin_reject, 1);
    check("ovf_balance", balance, 250);
    do_coin(2'd1);
    check("fill_reject", coin_reject, 0);
    check("fill_balance", balance, 255);
    do_coin(2'd1);
    check("full_reject", coin_reject, 1);
    check("full_balance", balance, 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vending_machine.md
VENDING_MACHINE -- requirements
Module: vending_machine

Interface
REQ-001 NUM_SLOTS, 6, number of item slots; fixed, not overridable.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 valid_s  input  1  1 = supplier (restock) mode, 0 = user mode.
REQ-005 item_s  input  3  slot to restock: 1..6 = slot 0..5; 0 and 7 = no slot.
REQ-006 count_s  input  4  restock quantity, 0..15.
REQ-007 cost_s  input  8  slot price in cents, 0..255.
REQ-008 enter_key  input  1  commit strobe, sampled each cycle.
REQ-009 coins  input  2  coin per cycle: 0 = none, 1 = nickel (5), 2 = dime (10), 3 = quarter (25).
REQ-010 button  input  6  one-hot user selection, bit n = slot n.
REQ-011 dispense  output  1  one-cycle pulse, item released.
REQ-012 dispense_item  output  3  dispensed slot number plus 1; 0 when no dispense.
REQ-013 change  output  8  refund amount, valid while dispense or refund is high.
REQ-014 refund  output  1  one-cycle pulse, cancel refund issued.
REQ-015 balance  output  8  current user credit in cents.
REQ-016 sold_out  output  1  one-cycle pulse, selected slot is empty.
REQ-017 insufficient  output  1  one-cycle pulse, credit is below the price.
REQ-018 coin_reject  output  1  one-cycle pulse, coin refused on overflow.

Function
REQ-019 Per slot, hold a count register (4 bits) and a cost register (8 bits).
REQ-020 Supplier mode, enter_key=1, item_s in 1..6: at the next edge, count and cost of slot item_s-1 load count_s and cost_s, overwriting previous values.
REQ-021 Supplier mode, item_s 0 or 7: enter_key is ignored.
REQ-022 Supplier mode: coins and button are ignored; balance is held.
REQ-023 User mode, coins!=0: balance += coin value at the next edge.
REQ-024 If balance + coin value > 255, the coin is not added and coin_reject pulses.
REQ-025 User mode, enter_key=1 with exactly one button bit set selects that slot; the decision uses the pre-edge balance.
REQ-026 Selected slot count == 0: sold_out pulses; balance is unchanged.
REQ-027 Otherwise, balance < cost: insufficient pulses; balance is unchanged.
REQ-028 Otherwise, a vend occurs.
  - Pulses: dispense, dispense_item = slot+1, change = balance - cost.
  - Slot count decrements by 1.
  - balance is cleared to 0.
REQ-029 enter_key=1 with more than one button bit set: no action, no flag.
REQ-030 Coin and enter_key in the same cycle: the vend or cancel decision uses the pre-edge balance; the coin value is then added to the resulting balance.
REQ-031 Latency: every output is registered and reflects the inputs sampled at the preceding edge.
REQ-032 All pulse outputs last exactly one cycle; enter_key held high re-evaluates every cycle.
REQ-033 A valid_s change preserves balance and all slot registers.

Reset
REQ-034 With rst=1 at an edge, all of the following clear to 0; rst has priority over all inputs:
  - every slot count and cost;
  - balance, change, dispense_item;
  - all pulse outputs.
REQ-035 After reset every selection reports sold_out until that slot is restocked.

Configuration
REQ-036 Macro VM_CANCEL_REFUND_EN, when defined: user-mode enter_key=1 with button==0 pulses refund, sets change = balance and clears balance; with balance 0, refund pulses with change 0.
REQ-037 Without VM_CANCEL_REFUND_EN: enter_key with button==0 is ignored and refund is held at 0.

Verification
REQ-038 Reset, then select button[2] in user mode -> sold_out=1 for one cycle, balance=0.
REQ-039 Restock item_s=3, count 2, cost 30; insert quarter+dime; select button[2] -> dispense=1, dispense_item=3, change=5, balance=0, slot count=1.
REQ-040 Slot cost 50, insert one quarter, select -> insufficient=1, balance stays 25.
REQ-041 Balance 250, insert a dime -> coin_reject=1, balance stays 250; a nickel then gives balance 255.
REQ-042 Restock slot count 1; vend twice with sufficient credit -> first dispenses, second gives sold_out.
REQ-043 With VM_CANCEL_REFUND_EN, balance 35, enter_key with button=0 -> refund=1, change=35, balance=0.
